accum_mem_arr: RTL and testbench

//  Per-row output/accumulator memory array for the systolic datapath: ACCUM_ROW independent lanes.

---
 rtl/accum_mem_pkg.sv | 43 ++++
 rtl/accum_mem_lane.sv | 110 +++++++++++
 rtl/accum_mem_arr.sv | 103 ++++++++++
 tb/tb_accum_mem_arr.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_mem_pkg.sv
// accum_mem_pkg: shared enums and the accumulate adder used by accum_mem_arr.
// Optional macro ACCUM_MEM_SAT_EN: accumulate saturates instead of wrapping.
package accum_mem_pkg;

  localparam int SAT_MAX_W = 64;

  typedef enum logic {
    WR_OVERWRITE = 1'b0,
    WR_ACCUM     = 1'b1
  } wr_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Operands arrive sign-extended to SAT_MAX_W; callers keep the low dw bits (dw < SAT_MAX_W).
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int                          dw
  );
    logic signed [SAT_MAX_W-1:0] sum;
`ifdef ACCUM_MEM_SAT_EN
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end else begin
      sum = sum;
    end
`else
    sum = (a + b) & ((64'sd1 <<< dw) - 64'sd1);
`endif
    return sum;
  endfunction

endpackage

// File: rtl/accum_mem_lane.sv
// accum_mem_lane: one lane of the accumulator store -- memory, two-stage
// overwrite/accumulate write pipeline with S1->S0 forwarding, registered read port.
module accum_mem_lane
  import accum_mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_ok_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_W-1:0]     clr_addr_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  wr_en_i,
  input  logic                  wr_acc_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  s1_valid_q;
  logic [ADDR_W-1:0]     s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_old_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  wr_mode_e              s1_mode_q;

  logic [DATA_WIDTH-1:0] commit_val_s;
  logic [DATA_WIDTH-1:0] old_s;
  logic                  wr_take_s;
  logic                  rd_take_s;

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  assign wr_take_s = wr_en_i & req_ok_i;
  assign rd_take_s = rd_en_i & req_ok_i;

  // Value S1 commits this cycle.
  always_comb begin
    commit_val_s = s1_data_q;
    case (s1_mode_q)
      WR_ACCUM: commit_val_s = DATA_WIDTH'(sat_add(SAT_MAX_W'(signed'(s1_old_q)),
                                                   SAT_MAX_W'(signed'(s1_data_q)),
                                                   DATA_WIDTH));
      WR_OVERWRITE: commit_val_s = s1_data_q;
      default:      commit_val_s = s1_data_q;
    endcase
  end

  // S0 old operand: the committing S1 value wins over the stale memory word.
  always_comb begin
    old_s = mem_q[wr_addr_i];
    if (s1_valid_q && (s1_addr_q == wr_addr_i)) begin
      old_s = commit_val_s;
    end else begin
      old_s = mem_q[wr_addr_i];
    end
  end

  // S0 -> S1 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_old_q   <= '0;
      s1_data_q  <= '0;
      s1_mode_q  <= WR_OVERWRITE;
    end else begin
      s1_valid_q <= wr_take_s;
      if (wr_take_s) begin
        s1_addr_q <= wr_addr_i;
        s1_old_q  <= old_s;
        s1_data_q <= wr_data_i;
        s1_mode_q <= wr_acc_i ? WR_ACCUM : WR_OVERWRITE;
      end
    end
  end

  // Memory write port: a clear sweep and an S1 commit never coincide; reset drops the commit.
  always_ff @(posedge clk) begin
    if (!rst && clr_en_i) begin
      mem_q[clr_addr_i] <= '0;
    end else if (!rst && s1_valid_q) begin
      mem_q[s1_addr_q] <= commit_val_s;
    end
  end

  // Registered read port; data holds between requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_take_s;
      if (rd_take_s) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/accum_mem_arr.sv
// accum_mem_arr: ACCUM_ROW-lane accumulator memory with a shared clear sequencer.
// Optional macro ACCUM_MEM_SAT_EN (see accum_mem_pkg) selects saturating accumulate.
module accum_mem_arr
  import accum_mem_pkg::*;
#(
  parameter  int ACCUM_ROW  = 256,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr_req,
  output logic                                 busy,
  input  logic [ACCUM_ROW-1:0]                 rd_en,
  input  logic [ACCUM_ROW-1:0][ADDR_W-1:0]     rd_addr,
  output logic [ACCUM_ROW-1:0][DATA_WIDTH-1:0] rd_data,
  output logic [ACCUM_ROW-1:0]                 rd_valid,
  input  logic [ACCUM_ROW-1:0]                 wr_en,
  input  logic [ACCUM_ROW-1:0]                 wr_acc,
  input  logic [ACCUM_ROW-1:0][ADDR_W-1:0]     wr_addr,
  input  logic [ACCUM_ROW-1:0][DATA_WIDTH-1:0] wr_data
);

  clr_state_e        state_q;
  clr_state_e        state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              busy_q;
  logic              req_ok_s;
  logic              clr_en_s;

  // Requests are dropped both on the clr_req edge and for the whole sweep.
  assign req_ok_s = (state_q == IDLE) && !clr_req;
  assign clr_en_s = (state_q == CLEAR);

  // Clear sequencer next-state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = CLEAR;
          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state, counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CLEAR);
    end
  end

  assign busy = busy_q;

  for (genvar g = 0; g < ACCUM_ROW; g++) begin : g_lane
    accum_mem_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .req_ok_i   (req_ok_s),
      .clr_en_i   (clr_en_s),
      .clr_addr_i (cnt_q),
      .rd_en_i    (rd_en[g]),
      .rd_addr_i  (rd_addr[g]),
      .rd_data_o  (rd_data[g]),
      .rd_valid_o (rd_valid[g]),
      .wr_en_i    (wr_en[g]),
      .wr_acc_i   (wr_acc[g]),
      .wr_addr_i  (wr_addr[g]),
      .wr_data_i  (wr_data[g])
    );
  end

endmodule

// File: tb/tb_accum_mem_arr.sv
// Self-checking bench for accum_mem_arr: directed scenarios plus random traffic
// compared every cycle against a transaction-level memory model.
module tb_accum_mem_arr;

  localparam int NR    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

`ifdef ACCUM_MEM_SAT_EN
  localparam logic [DW-1:0] OVF_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [DW-1:0] OVF_EXP = 32'h8000_0000;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clr_req;
  logic                   busy;
  logic [NR-1:0]          rd_en;
  logic [NR-1:0][AW-1:0]  rd_addr;
  logic [NR-1:0][DW-1:0]  rd_data;
  logic [NR-1:0]          rd_valid;
  logic [NR-1:0]          wr_en;
  logic [NR-1:0]          wr_acc;
  logic [NR-1:0][AW-1:0]  wr_addr;
  logic [NR-1:0][DW-1:0]  wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: committed memory, writes awaiting commit, remaining clear cycles.
  logic [DW-1:0]         m_mem [NR][DEPTH];
  logic [NR-1:0]         p_v;
  logic [NR-1:0]         p_acc;
  logic [AW-1:0]         p_addr [NR];
  logic [DW-1:0]         p_data [NR];
  int                    m_clr_left = 0;
  logic                  exp_busy;
  logic [NR-1:0]         exp_rd_valid;
  logic [NR-1:0][DW-1:0] exp_rd_data;

  always #5 clk = ~clk;

  accum_mem_arr #(
    .ACCUM_ROW  (NR),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_acc   (wr_acc),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  function automatic logic [DW-1:0] m_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    logic [63:0] u;
    s = longint'(signed'(a)) + longint'(signed'(b));
`ifdef ACCUM_MEM_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    u = 64'(s);
    return u[DW-1:0];
  endfunction

  task automatic model_edge();
    logic accept;
    if (rst) begin
      exp_busy     = 1'b0;
      exp_rd_valid = '0;
      exp_rd_data  = '0;
      p_v          = '0;
      m_clr_left   = 0;
      return;
    end
    accept = (m_clr_left == 0) && !clr_req;
    for (int l = 0; l < NR; l++) begin
      exp_rd_valid[l] = accept && rd_en[l];
      if (accept && rd_en[l]) exp_rd_data[l] = m_mem[l][rd_addr[l]];
    end
    for (int l = 0; l < NR; l++) begin
      if (p_v[l]) m_mem[l][p_addr[l]] = p_acc[l] ? m_add(m_mem[l][p_addr[l]], p_data[l]) : p_data[l];
    end
    if (m_clr_left > 0) begin
      for (int l = 0; l < NR; l++) m_mem[l][DEPTH - m_clr_left] = '0;
      m_clr_left--;
    end else if (clr_req) begin
      m_clr_left = DEPTH;
    end
    for (int l = 0; l < NR; l++) begin
      p_v[l]    = accept && wr_en[l];
      p_acc[l]  = wr_acc[l];
      p_addr[l] = wr_addr[l];
      p_data[l] = wr_data[l];
    end
    exp_busy = (m_clr_left > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    n_checks++;
    assert (busy === exp_busy) else begin
      n_fail++; $error("FAIL busy observed=%0b expected=%0b", busy, exp_busy);
    end
    n_checks++;
    assert (rd_valid === exp_rd_valid) else begin
      n_fail++; $error("FAIL rd_valid observed=%h expected=%h", rd_valid, exp_rd_valid);
    end
    n_checks++;
    assert (rd_data === exp_rd_data) else begin
      n_fail++; $error("FAIL rd_data observed=%h expected=%h", rd_data, exp_rd_data);
    end
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0; rd_en = '0; rd_addr = '0;
    wr_en = '0; wr_acc = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic random_inputs();
    rd_en  = NR'($urandom);
    wr_en  = NR'($urandom);
    wr_acc = NR'($urandom);
    for (int l = 0; l < NR; l++) begin
      rd_addr[l] = AW'($urandom_range(0, 3));
      wr_addr[l] = AW'($urandom_range(0, 3));
      wr_data[l] = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + DW'($urandom_range(0, 31))
                                                : DW'($urandom);
    end
  endtask

  // Counts busy cycles after the clr_req edge; noise drives ignored traffic meanwhile.
  task automatic count_busy(input bit noise, output int n);
    n = 0;
    for (int k = 0; k < DEPTH + 8 && busy === 1'b1; k++) begin
      n++;
      if (noise) random_inputs(); else idle_inputs();
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int nb;
    for (int l = 0; l < NR; l++)
      for (int a = 0; a < DEPTH; a++) m_mem[l][a] = '0;
    p_v = '0;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Full clear, then read every address of the edge lanes.
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    count_busy(1'b0, nb);
    n_checks++;
    assert (nb === DEPTH) else begin n_fail++; $error("FAIL clr_busy_len observed=%0d expected=%0d", nb, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_en[0] = 1'b1; rd_en[NR-1] = 1'b1;
      rd_addr[0] = AW'(a); rd_addr[NR-1] = AW'(a);
      tick();
      n_checks++;
      assert ((rd_data[0] === '0) && (rd_data[NR-1] === '0)) else begin
        n_fail++; $error("FAIL clr_read addr=%0d observed=%h/%h expected=0", a, rd_data[0], rd_data[NR-1]);
      end
    end
    idle_inputs(); tick();

    // Lane 3 overwrite then read two cycles later.
    wr_en[3] = 1'b1; wr_addr[3] = AW'(5); wr_data[3] = 32'h10;
    tick(); idle_inputs(); tick();
    rd_en[3] = 1'b1; rd_addr[3] = AW'(5);
    tick(); idle_inputs();
    n_checks++;
    assert ((rd_data[3] === 32'h10) && (rd_valid[3] === 1'b1)) else begin
      n_fail++; $error("FAIL ovw_read observed=%h/%b expected=10/1", rd_data[3], rd_valid[3]);
    end
    tick();
    n_checks++;
    assert (rd_valid[3] === 1'b0) else begin n_fail++; $error("FAIL rd_valid_pulse observed=%b expected=0", rd_valid[3]); end

    // Back-to-back accumulates into lane 7 addr 9.
    for (int v = 1; v <= 4; v++) begin
      wr_en[7] = 1'b1; wr_acc[7] = 1'b1; wr_addr[7] = AW'(9); wr_data[7] = DW'(v);
      tick();
    end
    idle_inputs(); tick(); tick();
    rd_en[7] = 1'b1; rd_addr[7] = AW'(9);
    tick(); idle_inputs();
    n_checks++;
    assert (rd_data[7] === 32'd10) else begin n_fail++; $error("FAIL fwd_sum observed=%0d expected=10", rd_data[7]); end

    // Accumulate overflow at lane 0 addr 0.
    wr_en[0] = 1'b1; wr_addr[0] = '0; wr_data[0] = 32'h7FFF_FFFF; tick();
    wr_acc[0] = 1'b1; wr_data[0] = 32'h1; tick();
    idle_inputs(); tick(); tick();
    rd_en[0] = 1'b1; rd_addr[0] = '0;
    tick(); idle_inputs();
    n_checks++;
    assert (rd_data[0] === OVF_EXP) else begin n_fail++; $error("FAIL ovf observed=%h expected=%h", rd_data[0], OVF_EXP); end

    // Random traffic with occasional clears.
    for (int t = 0; t < 400; t++) begin
      random_inputs();
      clr_req = ($urandom_range(0, 79) == 0);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < DEPTH + 4 && busy === 1'b1; k++) tick();
    tick(); tick();

    // Writes around and during a clear are dropped or overwritten.
    wr_en[2] = 1'b1; wr_addr[2] = AW'(4); wr_data[2] = 32'h55; tick();
    clr_req = 1'b1; wr_en = '1; wr_addr[2] = AW'(6); wr_data[2] = 32'h66; tick();
    count_busy(1'b1, nb);
    n_checks++;
    assert (nb === DEPTH) else begin n_fail++; $error("FAIL clr_noise_len observed=%0d expected=%0d", nb, DEPTH); end
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en[2] = 1'b1; rd_addr[2] = AW'(a);
      tick();
      n_checks++;
      assert (rd_data[2] === '0) else begin n_fail++; $error("FAIL clr_drop addr=%0d observed=%h expected=0", a, rd_data[2]); end
    end
    idle_inputs(); tick();

    // Reset in the middle of a clear, then a full sweep again.
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (DEPTH / 2) tick();
    rst = 1'b1; rd_en = '1; tick();
    n_checks++;
    assert ((busy === 1'b0) && (rd_valid === '0)) else begin
      n_fail++; $error("FAIL rst_abort observed=%b/%h expected=0/0", busy, rd_valid);
    end
    rst = 1'b0; idle_inputs(); tick();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    count_busy(1'b0, nb);
    n_checks++;
    assert (nb === DEPTH) else begin n_fail++; $error("FAIL clr_after_rst_len observed=%0d expected=%0d", nb, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = '1; rd_addr = '0;
      for (int l = 0; l < NR; l++) rd_addr[l] = AW'(a);
      tick();
    end
    idle_inputs(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
